tag_free_list: RTL

TAG_FREE_LIST -- requirements
Module: tag_free_list

---
 rtl/tag_pkg.sv | 19 +
 rtl/tag_rel_compact.sv | 38 +++
 rtl/tag_free_list.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tag_pkg.sv
// ============================================================================
// Module      : tag_pkg
// Description : Shared tag width, tag type and parameter defaults for the
//               physical-tag free list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_pkg;
  localparam int NUM_TAGS_DEF    = 128;
  localparam int ARCH_REGS_DEF   = 32;
  localparam int ALLOC_PORTS_DEF = 2;
  localparam int REL_PORTS_DEF   = 2;
  localparam int TAG_W           = $clog2(NUM_TAGS_DEF);

  typedef logic [TAG_W-1:0] tag_t;
endpackage

`default_nettype wire

// File: rtl/tag_rel_compact.sv
// ============================================================================
// Module      : tag_rel_compact
// Description : Packs valid release lanes into consecutive slots in ascending
//               lane order and counts them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_rel_compact
  import tag_pkg::*;
#(
  parameter int REL_PORTS = REL_PORTS_DEF
) (
  input  logic [REL_PORTS-1:0]         rel_valid,
  input  logic [REL_PORTS*TAG_W-1:0]   rel_tag,
  output logic [REL_PORTS*TAG_W-1:0]   comp_tag,
  output logic [$clog2(REL_PORTS+1)-1:0] rel_cnt
);

  localparam int RCNT_W = $clog2(REL_PORTS+1);

  int w_n;

  always_comb begin
    comp_tag = '0;
    w_n      = 0;
    for (int i = 0; i < REL_PORTS; i++) begin
      if (rel_valid[i]) begin
        comp_tag[w_n*TAG_W +: TAG_W] = rel_tag[i*TAG_W +: TAG_W];
        w_n = w_n + 1;
      end
    end
    rel_cnt = RCNT_W'(w_n);
  end

endmodule

`default_nettype wire

// File: rtl/tag_free_list.sv
// ============================================================================
// Module      : tag_free_list
// Description : Circular FIFO of free physical tags with multi-lane alloc and
//               release. Optional rptr checkpoint: TAG_FREE_LIST_CKPT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_free_list
  import tag_pkg::*;
#(
  parameter int NUM_TAGS    = NUM_TAGS_DEF,
  parameter int ARCH_REGS   = ARCH_REGS_DEF,
  parameter int ALLOC_PORTS = ALLOC_PORTS_DEF,
  parameter int REL_PORTS   = REL_PORTS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(ALLOC_PORTS+1)-1:0] alloc_cnt,
  output logic                             alloc_ok,
  output logic [ALLOC_PORTS*TAG_W-1:0]     alloc_tag,
  input  logic [REL_PORTS-1:0]             rel_valid,
  input  logic [REL_PORTS*TAG_W-1:0]       rel_tag,
  output logic [$clog2(NUM_TAGS):0]        free_count,
  output logic                             rel_overflow
`ifdef TAG_FREE_LIST_CKPT_EN
  ,
  input  logic                             ckpt_save,
  input  logic                             ckpt_restore
`endif
);

  localparam int IDX_W  = $clog2(NUM_TAGS);
  localparam int PTR_W  = IDX_W + 1;
  localparam int RCNT_W = $clog2(REL_PORTS+1);
  localparam logic [PTR_W-1:0] c_wptr_init = PTR_W'(NUM_TAGS - ARCH_REGS);

  tag_t                        r_mem [NUM_TAGS];
  logic [PTR_W-1:0]            r_rptr;
  logic [PTR_W-1:0]            r_wptr;
  logic                        r_overflow;
  logic [PTR_W-1:0]            w_rptr_next;
  logic [REL_PORTS*TAG_W-1:0]  w_comp_tag;
  logic [RCNT_W-1:0]           w_rel_cnt;
  logic                        w_rel_drop;

  tag_rel_compact #(
    .REL_PORTS (REL_PORTS)
  ) u_compact (
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .comp_tag  (w_comp_tag),
    .rel_cnt   (w_rel_cnt)
  );

  assign free_count   = r_wptr - r_rptr;
  assign alloc_ok     = free_count >= PTR_W'(alloc_cnt);
  assign rel_overflow = r_overflow;

  // Releases are judged against the pre-allocation count, so a same-cycle
  // grant never makes room for them.
  assign w_rel_drop = ({1'b0, free_count} + (PTR_W+1)'(w_rel_cnt))
                      > (PTR_W+1)'(NUM_TAGS);

  generate
    for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_peek
      logic [PTR_W-1:0] w_ptr;
      assign w_ptr = r_rptr + PTR_W'(k);
      assign alloc_tag[k*TAG_W +: TAG_W] = r_mem[w_ptr[IDX_W-1:0]];
    end
  endgenerate

`ifdef TAG_FREE_LIST_CKPT_EN
  logic [PTR_W-1:0] r_ckpt;

  always_comb begin
    w_rptr_next = r_rptr;
    if (ckpt_restore) begin
      w_rptr_next = r_ckpt;
    end else if (alloc_ok) begin
      w_rptr_next = r_rptr + PTR_W'(alloc_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ckpt <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      r_ckpt <= w_rptr_next;
    end
  end
`else
  always_comb begin
    w_rptr_next = r_rptr;
    if (alloc_ok) begin
      w_rptr_next = r_rptr + PTR_W'(alloc_cnt);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_mem[i] <= (i < NUM_TAGS - ARCH_REGS) ? tag_t'(i + ARCH_REGS) : '0;
      end
      r_rptr     <= '0;
      r_wptr     <= c_wptr_init;
      r_overflow <= 1'b0;
    end else begin
      r_rptr <= w_rptr_next;
      if (w_rel_drop) begin
        r_overflow <= 1'b1;
      end else begin
        for (int j = 0; j < REL_PORTS; j++) begin
          if (j < int'(w_rel_cnt)) begin
            r_mem[IDX_W'(r_wptr + PTR_W'(j))] <= w_comp_tag[j*TAG_W +: TAG_W];
          end
        end
        r_wptr <= r_wptr + PTR_W'(w_rel_cnt);
      end
    end
  end

endmodule

`default_nettype wire
